// File: rtl/dkong_dma_pkg.sv
// dkong_dma_pkg: shared types and constants for the object-RAM DMA engine.
// Holds the Z80 bus bundles, register offsets, CTRL bit positions, FSM states.
package dkong_dma_pkg;

   // Master-side bus bundle, mirrors the Z80 bus header layout.
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  dmaster;
      logic        rdn;
      logic        wrn;
      logic        inta;
   } Z80MasterBus;

   // Slave-side return bundle.
   typedef struct packed {
      logic [7:0] dslave;
      logic       mwait;
   } Z80SlaveBus;

   localparam logic [3:0] REG_SRC  = 4'h0;
   localparam logic [3:0] REG_DST  = 4'h1;
   localparam logic [3:0] REG_LEN  = 4'h2;
   localparam logic [3:0] REG_CTRL = 4'h8;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_WR,
      S_INC,
      S_DONE
   } dma_state_t;

   // Replace one byte of a 16-bit register; hi selects the upper byte.
   function automatic logic [15:0] put_byte(
      input logic [15:0] v,
      input logic        hi,
      input logic [7:0]  b
   );
      logic [15:0] r;
      r = v;
      if (hi) r[15:8] = b;
      else    r[7:0]  = b;
      return r;
   endfunction

endpackage

// File: rtl/dkong_dma_regs.sv
// dkong_dma_regs: CPU-visible register file, byte pointer, shadows, status.
// Ports: ibus/ena register access in, obus readback out, done from the FSM,
// src_sh/dst_sh/len_sh shadow values, en/autoload control bits, tc status.
module dkong_dma_regs
   import dkong_dma_pkg::*;
#(
   parameter int LEN_W = 14
) (
   input  logic              masterclk,
   input  logic              rst_n,
   input  logic              ena,
   input  Z80MasterBus       ibus,
   output Z80SlaveBus        obus,
   input  logic              done,
   output logic [15:0]       src_sh,
   output logic [15:0]       dst_sh,
   output logic [LEN_W-1:0]  len_sh,
   output logic              en,
   output logic              autoload,
   output logic              tc
);

   logic              wr_req;
   logic              rd_req;
   logic              wr_q;
   logic              rd_q;
   logic              wr_stb;
   logic              rd_stb;
   logic [3:0]        off;
   logic [7:0]        wd;

   logic [15:0]       src_r;
   logic [15:0]       dst_r;
   logic [LEN_W-1:0]  len_r;
   logic              ptr;

   logic [15:0]       src_nx;
   logic [15:0]       dst_nx;
   logic [LEN_W-1:0]  len_nx;
   logic [15:0]       len16;
   logic              ptr_nx;
   logic              en_nx;
   logic              auto_nx;
   logic              tc_nx;

   logic              unused;

   assign off    = ibus.addr[3:0];
   assign wd     = ibus.dmaster;
   assign wr_req = ena & ~ibus.wrn;
   assign rd_req = ena & ~ibus.rdn;

   // A CPU access may hold its strobe for several clocks; act once per
   // access so the byte pointer advances exactly one step.
   assign wr_stb = wr_req & ~wr_q;
   assign rd_stb = rd_req & ~rd_q;

   assign unused = ^{ibus.addr[15:4], ibus.inta};

   always_comb begin
      obus.mwait  = 1'b1;
      obus.dslave = 8'h00;
      if (ena && off == REG_CTRL) begin
         obus.dslave = {7'b0, tc};
      end
   end

   always_comb begin
      src_nx  = src_r;
      dst_nx  = dst_r;
      len_nx  = len_r;
      len16   = 16'(len_r);
      ptr_nx  = ptr;
      en_nx   = en;
      auto_nx = autoload;
      tc_nx   = tc;

      if (rd_stb && off == REG_CTRL) begin
         tc_nx = 1'b0;
      end

      if (done) begin
         tc_nx = 1'b1;
         if (!autoload) begin
            en_nx = 1'b0;
         end
      end

      if (wr_stb) begin
         unique case (off)
            REG_SRC: begin
               src_nx = put_byte(src_r, ptr, wd);
               ptr_nx = ~ptr;
            end
            REG_DST: begin
               dst_nx = put_byte(dst_r, ptr, wd);
               ptr_nx = ~ptr;
            end
            REG_LEN: begin
               // Bits above LEN_W are dropped here.
               len16  = put_byte(16'(len_r), ptr, wd);
               len_nx = len16[LEN_W-1:0];
               ptr_nx = ~ptr;
            end
            REG_CTRL: begin
               en_nx   = wd[CTRL_EN];
               auto_nx = wd[CTRL_AUTO];
               ptr_nx  = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge masterclk) begin
      if (!rst_n) begin
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         src_r    <= 16'h0000;
         dst_r    <= 16'h0000;
         len_r    <= '0;
         src_sh   <= 16'h0000;
         dst_sh   <= 16'h0000;
         len_sh   <= '0;
         ptr      <= 1'b0;
         en       <= 1'b0;
         autoload <= 1'b0;
         tc       <= 1'b0;
      end else begin
         wr_q     <= wr_req;
         rd_q     <= rd_req;
         src_r    <= src_nx;
         dst_r    <= dst_nx;
         len_r    <= len_nx;
         ptr      <= ptr_nx;
         en       <= en_nx;
         autoload <= auto_nx;
         tc       <= tc_nx;
         if (wr_stb) begin
            src_sh <= src_nx;
            dst_sh <= dst_nx;
            len_sh <= len_nx;
         end
      end
   end

endmodule

// File: rtl/dkong_dma.sv
// dkong_dma: single-channel bus-master DMA, work RAM to object RAM.
// Ports: masterclk/rst_n, ena+ibus/obus register port, dma_rdy trigger,
// busrq_n/busak_n CPU handshake, mbus/mbus_in master port, msel, tc.
module dkong_dma
   import dkong_dma_pkg::*;
#(
   parameter int ACC_CYCLES = 2,
   parameter int LEN_W      = 14
) (
   input  logic        masterclk,
   input  logic        rst_n,
   input  logic        ena,
   input  Z80MasterBus ibus,
   output Z80SlaveBus  obus,
   input  logic        dma_rdy,
   output logic        busrq_n,
   input  logic        busak_n,
   output Z80MasterBus mbus,
   input  Z80SlaveBus  mbus_in,
   output logic        msel,
   output logic        tc
);

   localparam int ACW =
      (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [ACW-1:0] ACC_LAST =
      ACW'(ACC_CYCLES - 1);
   localparam logic [LEN_W-1:0] CNT_ONE = 1;

   dma_state_t        state;
   dma_state_t        state_nx;

   logic              rdy_q;
   logic              trig_q;

   logic [15:0]       src_w;
   logic [15:0]       dst_w;
   logic [LEN_W-1:0]  cnt_w;
   logic [7:0]        data_q;
   logic [ACW-1:0]    acc;

   logic [15:0]       src_nx;
   logic [15:0]       dst_nx;
   logic [LEN_W-1:0]  cnt_nx;
   logic [7:0]        data_nx;
   logic [ACW-1:0]    acc_nx;

   logic [15:0]       src_sh;
   logic [15:0]       dst_sh;
   logic [LEN_W-1:0]  len_sh;
   logic              en;
   logic              autoload;
   logic              done;

   assign done = (state == S_DONE);

   dkong_dma_regs #(
      .LEN_W (LEN_W)
   ) u_regs (
      .masterclk (masterclk),
      .rst_n     (rst_n),
      .ena       (ena),
      .ibus      (ibus),
      .obus      (obus),
      .done      (done),
      .src_sh    (src_sh),
      .dst_sh    (dst_sh),
      .len_sh    (len_sh),
      .en        (en),
      .autoload  (autoload),
      .tc        (tc)
   );

   always_ff @(posedge masterclk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         rdy_q  <= 1'b0;
         trig_q <= 1'b0;
         src_w  <= 16'h0000;
         dst_w  <= 16'h0000;
         cnt_w  <= '0;
         data_q <= 8'h00;
         acc    <= '0;
      end else begin
         state  <= state_nx;
         rdy_q  <= dma_rdy;
         // Registered edge: adds the extra cycle before REQ.
         trig_q <= dma_rdy & ~rdy_q;
         src_w  <= src_nx;
         dst_w  <= dst_nx;
         cnt_w  <= cnt_nx;
         data_q <= data_nx;
         acc    <= acc_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      src_nx       = src_w;
      dst_nx       = dst_w;
      cnt_nx       = cnt_w;
      data_nx      = data_q;
      acc_nx       = acc;
      busrq_n      = 1'b1;
      msel         = 1'b0;
      mbus.addr    = 16'h0000;
      mbus.dmaster = 8'h00;
      mbus.rdn     = 1'b1;
      mbus.wrn     = 1'b1;
      mbus.inta    = 1'b1;

      unique case (state)
         S_IDLE: begin
            src_nx = src_sh;
            dst_nx = dst_sh;
            cnt_nx = len_sh;
            acc_nx = '0;
            if (trig_q && en) begin
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            busrq_n = 1'b0;
            if (!en) begin
               state_nx = S_IDLE;
            end else if (!busak_n) begin
               state_nx = S_RD;
            end
         end
         S_RD: begin
            busrq_n   = 1'b0;
            msel      = 1'b1;
            mbus.addr = src_w;
            mbus.rdn  = 1'b0;
            // acc only advances on cycles the slave is ready.
            if (mbus_in.mwait) begin
               if (acc == ACC_LAST) begin
                  data_nx  = mbus_in.dslave;
                  acc_nx   = '0;
                  state_nx = S_WR;
               end else begin
                  acc_nx = acc + ACW'(1);
               end
            end
         end
         S_WR: begin
            busrq_n      = 1'b0;
            msel         = 1'b1;
            mbus.addr    = dst_w;
            mbus.dmaster = data_q;
            mbus.wrn     = 1'b0;
            if (mbus_in.mwait) begin
               if (acc == ACC_LAST) begin
                  acc_nx   = '0;
                  state_nx = S_INC;
               end else begin
                  acc_nx = acc + ACW'(1);
               end
            end
         end
         S_INC: begin
            busrq_n = 1'b0;
            msel    = 1'b1;
            src_nx  = src_w + 16'd1;
            dst_nx  = dst_w + 16'd1;
            if (cnt_w == '0) begin
               state_nx = S_DONE;
            end else begin
               cnt_nx   = cnt_w - CNT_ONE;
               state_nx = S_RD;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule
